// File: rtl/imem_loader_pkg.sv
// imem_loader shared definitions.
// FSM encodings, mode codes and default widths.
package imem_loader_pkg;

    localparam int D_WIDTH_DEF = 32;
    localparam int A_WIDTH_DEF = 10;
    localparam int C_WIDTH_DEF = 11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic MODE_WRITE  = 1'b0;
    localparam logic MODE_VERIFY = 1'b1;

endpackage

// File: rtl/imem_loader_if.sv
// Stream source and SRAM load-port bundle for imem_loader.
// master = the loader, slave = the source/SRAM side.
interface imem_loader_if #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 10
);

    logic [D_WIDTH-1:0] S_data;
    logic               S_valid;
    logic               S_ready;
    logic [D_WIDTH-1:0] M_di;
    logic [A_WIDTH-1:0] MI_Addr;
    logic               M_enb;
    logic               M_web;
    logic [D_WIDTH-1:0] MO_do;

    modport master (
        input  S_data,
        input  S_valid,
        input  MO_do,
        output S_ready,
        output M_di,
        output MI_Addr,
        output M_enb,
        output M_web
    );

    modport slave (
        output S_data,
        output S_valid,
        output MO_do,
        input  S_ready,
        input  M_di,
        input  MI_Addr,
        input  M_enb,
        input  M_web
    );

endinterface

// File: rtl/imem_loader.sv
// Streams a program image into instruction SRAM, optionally verifying it.
// Holds the core in reset while a transfer runs.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int C_WIDTH = C_WIDTH_DEF
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic               Mode,
    input  logic [A_WIDTH-1:0] Base,
    input  logic [C_WIDTH-1:0] Count,
    input  logic               Abort,
    imem_loader_if.master      lif,
    output logic               Core_Rst,
    output logic               Busy,
    output logic               Done,
    output logic               Aborted,
    output logic               Err,
    output logic [A_WIDTH-1:0] Err_Addr
);

    logic [1:0]         state_q, state_d;
    logic               mode_q, mode_d;
    logic [A_WIDTH-1:0] base_q, base_d;
    logic [C_WIDTH-1:0] count_q, count_d;
    logic [C_WIDTH-1:0] idx_q, idx_d;
    logic               enb_q, enb_d;
    logic               web_q, web_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [D_WIDTH-1:0] di_q, di_d;
    logic               cmp_q, cmp_d;
    logic [D_WIDTH-1:0] exp_q, exp_d;
    logic [A_WIDTH-1:0] exp_addr_q, exp_addr_d;
    logic               err_q, err_d;
    logic [A_WIDTH-1:0] err_addr_q, err_addr_d;
    logic               aborted_q, aborted_d;

    logic idle_done;
    logic start_acc;
    logic hs;
    logic last;
    logic cmp_fail;

    assign idle_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign start_acc = Start & idle_done;
    assign hs        = (state_q == ST_RUN) & lif.S_valid & ~Abort;
    assign last      = (idx_q == count_q - C_WIDTH'(1));
    assign cmp_fail  = cmp_q & (lif.MO_do != exp_q);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        base_d    = base_q;
        count_d   = count_q;
        idx_d     = idx_q;
        aborted_d = aborted_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    mode_d    = Mode;
                    base_d    = Base;
                    count_d   = Count;
                    idx_d     = '0;
                    aborted_d = 1'b0;
                    state_d   = (Count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (Abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (hs) begin
                    idx_d = idx_q + C_WIDTH'(1);
                    if (last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                aborted_d = Abort;
                state_d   = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One registered SRAM op per accepted word; address wraps modulo depth.
    always_comb begin
        enb_d  = hs;
        web_d  = hs & (mode_q == MODE_WRITE);
        addr_d = addr_q;
        di_d   = di_q;
        if (hs) begin
            addr_d = base_q + idx_q[A_WIDTH-1:0];
            di_d   = lif.S_data;
        end
    end

    // Expected word trails each read by one cycle, lined up with MO_do.
    always_comb begin
        cmp_d      = enb_q & ~web_q;
        exp_d      = di_q;
        exp_addr_d = addr_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (start_acc) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end else if (cmp_fail && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = exp_addr_q;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_WRITE;
            base_q     <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            enb_q      <= 1'b0;
            web_q      <= 1'b0;
            addr_q     <= '0;
            di_q       <= '0;
            cmp_q      <= 1'b0;
            exp_q      <= '0;
            exp_addr_q <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            base_q     <= base_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            enb_q      <= enb_d;
            web_q      <= web_d;
            addr_q     <= addr_d;
            di_q       <= di_d;
            cmp_q      <= cmp_d;
            exp_q      <= exp_d;
            exp_addr_q <= exp_addr_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            aborted_q  <= aborted_d;
        end
    end

    assign lif.S_ready = (state_q == ST_RUN) & ~Abort;
    assign lif.M_enb   = enb_q;
    assign lif.M_web   = web_q;
    assign lif.MI_Addr = addr_q;
    assign lif.M_di    = di_q;

    assign Busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign Done     = (state_q == ST_DONE);
    assign Aborted  = aborted_q;
    assign Err      = err_q;
    assign Err_Addr = err_addr_q;

    // The final verify compare lands in the first DONE cycle, so fold it in.
    assign Core_Rst = (state_q == ST_DONE)
                    ? (aborted_q
                       | ((mode_q == MODE_VERIFY) & (err_q | cmp_fail)))
                    : 1'b1;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader.
// Behavioural SRAM with one-cycle read latency and a write log.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        Start;
    logic        Mode;
    logic [9:0]  Base;
    logic [10:0] Count;
    logic        Abort;
    logic        Core_Rst;
    logic        Busy;
    logic        Done;
    logic        Aborted;
    logic        Err;
    logic [9:0]  Err_Addr;

    int checks;
    int errors;
    int cyc;

    logic [31:0] mem [0:1023];
    logic [31:0] rdata;
    logic [31:0] src [0:15];
    logic [9:0]  wr_addr [$];
    int          wr_cyc  [$];
    bit          chk_enb;

    imem_loader_if #(.D_WIDTH(32), .A_WIDTH(10)) lif ();

    imem_loader dut (
        .Clk      (clk),
        .Rst      (rst),
        .Start    (Start),
        .Mode     (Mode),
        .Base     (Base),
        .Count    (Count),
        .Abort    (Abort),
        .lif      (lif),
        .Core_Rst (Core_Rst),
        .Busy     (Busy),
        .Done     (Done),
        .Aborted  (Aborted),
        .Err      (Err),
        .Err_Addr (Err_Addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign lif.MO_do = rdata;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (lif.M_enb) begin
            if (lif.M_web) begin
                mem[lif.MI_Addr] = lif.M_di;
                wr_addr.push_back(lif.MI_Addr);
                wr_cyc.push_back(cyc);
            end else begin
                rdata <= mem[lif.MI_Addr];
            end
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic m,
                              input logic [9:0] b,
                              input logic [10:0] c);
        Mode  = m;
        Base  = b;
        Count = c;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic feed(input int n, input bit toggle);
        int i;
        int guard;
        bit ph;
        logic hs;
        i     = 0;
        guard = 0;
        ph    = 1'b1;
        while (i < n && guard < 200) begin
            lif.S_valid = toggle ? ph : 1'b1;
            lif.S_data  = src[i];
            ph = ~ph;
            @(negedge clk);
            hs = lif.S_valid & lif.S_ready;
            tick();
            if (chk_enb) check("enb_follows_hs", lif.M_enb, hs);
            if (hs) i++;
            guard++;
        end
        lif.S_valid = 1'b0;
        check("feed_count", i, n);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (!Done && guard < 20) begin
            tick();
            guard++;
        end
        check("done_timeout", Done, 1'b1);
    endtask

    task automatic clr_log();
        wr_addr.delete();
        wr_cyc.delete();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        rdata       = '0;
        chk_enb     = 1'b0;
        rst         = 1'b0;
        Start       = 1'b0;
        Mode        = 1'b0;
        Base        = '0;
        Count       = '0;
        Abort       = 1'b0;
        lif.S_valid = 1'b0;
        lif.S_data  = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // reset values
        #12;
        check("rst_core", Core_Rst, 1'b1);
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_ready", lif.S_ready, 1'b0);
        check("rst_enb", lif.M_enb, 1'b0);
        check("rst_err", Err, 1'b0);
        rst = 1'b1;
        tick();

        // 1: write 4 words from base 0
        for (int i = 0; i < 4; i++) src[i] = 32'hA0 + i;
        clr_log();
        start_xfer(1'b0, 10'h000, 11'd4);
        check("t1_busy", Busy, 1'b1);
        feed(4, 1'b0);
        check("t1_drain_done", Done, 1'b0);
        check("t1_drain_ready", lif.S_ready, 1'b0);
        check("t1_drain_core", Core_Rst, 1'b1);
        tick();
        check("t1_done", Done, 1'b1);
        check("t1_core", Core_Rst, 1'b0);
        check("t1_busy_end", Busy, 1'b0);
        tick();
        check("t1_nwr", wr_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", wr_addr[i], i);
            check("t1_cyc", wr_cyc[i] - wr_cyc[0], i);
            check("t1_mem", mem[i], 32'hA0 + i);
        end

        // 2: address wrap at top of SRAM
        for (int i = 0; i < 4; i++) src[i] = 32'hB0 + i;
        clr_log();
        start_xfer(1'b0, 10'h3FE, 11'd4);
        feed(4, 1'b0);
        wait_done();
        tick();
        check("t2_nwr", wr_addr.size(), 4);
        check("t2_a0", wr_addr[0], 10'h3FE);
        check("t2_a1", wr_addr[1], 10'h3FF);
        check("t2_a2", wr_addr[2], 10'h000);
        check("t2_a3", wr_addr[3], 10'h001);
        check("t2_mem", mem[0], 32'hB2);

        // 3: verify with one bad word
        for (int i = 0; i < 4; i++) mem[10'h010 + i] = 32'hA0 + i;
        src[0] = 32'hA0;
        src[1] = 32'hA1;
        src[2] = 32'hFF;
        src[3] = 32'hA3;
        clr_log();
        start_xfer(1'b1, 10'h010, 11'd4);
        check("t3_core_run", Core_Rst, 1'b1);
        feed(4, 1'b0);
        tick();
        check("t3_done", Done, 1'b1);
        check("t3_err", Err, 1'b1);
        check("t3_err_addr", Err_Addr, 10'h012);
        check("t3_core", Core_Rst, 1'b1);
        tick();
        check("t3_core_hold", Core_Rst, 1'b1);
        check("t3_err_addr2", Err_Addr, 10'h012);
        check("t3_nwr", wr_addr.size(), 0);

        // 4: bubbly source, M_enb must track handshakes
        for (int i = 0; i < 8; i++) src[i] = 32'hC0 + i;
        clr_log();
        start_xfer(1'b0, 10'h040, 11'd8);
        check("t4_err_clr", Err, 1'b0);
        chk_enb = 1'b1;
        feed(8, 1'b1);
        chk_enb = 1'b0;
        wait_done();
        tick();
        check("t4_nwr", wr_addr.size(), 8);
        check("t4_mem7", mem[10'h047], 32'hC7);
        check("t4_core", Core_Rst, 1'b0);

        // 5: abort together with the 3rd handshake
        for (int i = 0; i < 8; i++) src[i] = 32'hD0 + i;
        clr_log();
        start_xfer(1'b0, 10'h080, 11'd8);
        feed(2, 1'b0);
        lif.S_valid = 1'b1;
        lif.S_data  = src[2];
        Abort       = 1'b1;
        tick();
        Abort       = 1'b0;
        lif.S_valid = 1'b0;
        check("t5_done", Done, 1'b1);
        check("t5_aborted", Aborted, 1'b1);
        check("t5_core", Core_Rst, 1'b1);
        check("t5_enb", lif.M_enb, 1'b0);
        check("t5_ready", lif.S_ready, 1'b0);
        tick();
        check("t5_nwr", wr_addr.size(), 2);
        check("t5_mem2", mem[10'h082], 32'h0);
        start_xfer(1'b0, 10'h000, 11'd0);
        check("t5_zero_done", Done, 1'b1);
        check("t5_zero_abort", Aborted, 1'b0);
        check("t5_zero_core", Core_Rst, 1'b0);

        // 6: Start ignored in RUN, then async reset mid-transfer
        for (int i = 0; i < 8; i++) src[i] = 32'hE0 + i;
        clr_log();
        start_xfer(1'b0, 10'h100, 11'd8);
        feed(3, 1'b0);
        lif.S_valid = 1'b1;
        lif.S_data  = src[3];
        start_xfer(1'b0, 10'h000, 11'd0);
        check("t6_ign_busy", Busy, 1'b1);
        check("t6_ign_done", Done, 1'b0);
        check("t6_ign_core", Core_Rst, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_core", Core_Rst, 1'b1);
        check("t6_rst_busy", Busy, 1'b0);
        check("t6_rst_done", Done, 1'b0);
        check("t6_rst_enb", lif.M_enb, 1'b0);
        check("t6_rst_web", lif.M_web, 1'b0);
        check("t6_rst_ready", lif.S_ready, 1'b0);
        lif.S_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("t6_idle_busy", Busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
